// File: rtl/i2s_wave_sequencer_pkg.sv
// Shared types and table constants for the I2S waveform sequencer.
package i2s_wave_pkg;

   localparam int SINE_LEN = 44;
   localparam int TRI_LEN  = 16;
   localparam int SAMPLE_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TICK,
      PRESENT,
      DONE
   } seq_state_e;

   // A masked channel carries silence rather than the ROM value.
   function automatic logic [SAMPLE_W-1:0] mask_chan(input logic en,
                                                     input logic [SAMPLE_W-1:0] v);
      return en ? v : '0;
   endfunction

endpackage

// File: rtl/i2s_wave_sequencer_if.sv
// Stereo sample handshake between the sequencer and the I2S writer.
interface i2s_wave_sequencer_if;
   import i2s_wave_pkg::*;

   logic [2*SAMPLE_W-1:0] sample_data;
   logic                  sample_valid;
   logic                  sample_ready;

   modport master (output sample_data, output sample_valid, input sample_ready);
   modport slave  (input sample_data, input sample_valid, output sample_ready);

endinterface

// File: rtl/i2s_wave_sequencer_sample_rate_divider.sv
// Down-counting sample-rate divider; tick fires while running and the count is zero.
module sample_rate_divider #(
   parameter int SAMPLE_DIV = 2267
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic run_i,
   output logic tick_o
);

   localparam int               CNT_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = run_i && (cnt_q == '0);

   // Loading zero makes the first tick land on the cycle right after start.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= RELOAD;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2s_wave_sequencer.sv
// Walks the waveform ROM one position per sample tick and offers each stereo sample to the I2S writer.
module i2s_wave_sequencer
   import i2s_wave_pkg::*;
#(
   parameter int SAMPLE_DIV = 2267
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                wave_sel,
   input  logic [15:0]         period_count,
   input  logic [1:0]          channel_mask,
   output logic                rom_sel,
   output logic [7:0]          rom_pos,
   input  logic [7:0]          rom_wavelength,
   input  logic [SAMPLE_W-1:0] rom_value,
   i2s_wave_sequencer_if.master smp,
   output logic                busy,
   output logic                done,
   output logic                underrun
);

   seq_state_e            state_q, state_d;
   logic                  en_q;
   logic                  sel_q, sel_d;
   logic [7:0]            pos_q, pos_d;
   logic [15:0]           per_q, per_d;
   logic [2*SAMPLE_W-1:0] data_q, data_d;
   logic                  urun_q, urun_d;
   logic                  div_load, div_run, tick;
   logic [7:0]            last_pos;

   sample_rate_divider #(.SAMPLE_DIV(SAMPLE_DIV)) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (div_load),
      .run_i  (div_run),
      .tick_o (tick)
   );

   // A zero-length table behaves as a single-entry table.
   assign last_pos = (rom_wavelength == 8'd0) ? 8'd0 : rom_wavelength - 8'd1;
   assign div_run  = (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      pos_d    = pos_q;
      per_d    = per_q;
      data_d   = data_q;
      urun_d   = urun_q;
      div_load = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable && !en_q) begin
               state_d  = WAIT_TICK;
               div_load = 1'b1;
               pos_d    = 8'd0;
               sel_d    = wave_sel;
               per_d    = 16'd0;
               urun_d   = 1'b0;
            end
         end
         WAIT_TICK: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (tick) begin
               data_d  = {mask_chan(channel_mask[1], rom_value),
                          mask_chan(channel_mask[0], rom_value)};
               state_d = PRESENT;
               // Table selection only changes at a period boundary.
               if (pos_q >= last_pos) begin
                  pos_d = 8'd0;
                  sel_d = wave_sel;
                  if (per_q != 16'hFFFF) per_d = per_q + 16'd1;
               end else begin
                  pos_d = pos_q + 8'd1;
               end
            end
         end
         PRESENT: begin
            if (tick) urun_d = 1'b1;
            if (smp.sample_ready) begin
               if (period_count != 16'd0 && per_q == period_count) state_d = DONE;
               else if (!enable)                                   state_d = IDLE;
               else                                                state_d = WAIT_TICK;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         en_q    <= 1'b0;
         sel_q   <= 1'b0;
         pos_q   <= 8'd0;
         per_q   <= 16'd0;
         data_q  <= '0;
         urun_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         en_q    <= enable;
         sel_q   <= sel_d;
         pos_q   <= pos_d;
         per_q   <= per_d;
         data_q  <= data_d;
         urun_q  <= urun_d;
      end
   end

   assign rom_sel          = sel_q;
   assign rom_pos          = pos_q;
   assign smp.sample_data  = data_q;
   assign smp.sample_valid = (state_q == PRESENT);
   assign busy             = (state_q != IDLE);
   assign done             = (state_q == DONE);
   assign underrun         = urun_q;

endmodule

// File: doc/i2s_wave_sequencer.md
# i2s_wave_sequencer

Sequencer that drives the combinational `waveform` ROM (sine 44-point / triangle 16-point) and delivers one stereo sample per sample-rate tick to the I2S transmit path over a valid/ready handshake. It owns the ROM address, selects the table at period boundaries, counts played periods, and flags underruns when the sink stalls past a tick. It sits between register-bank control bits and the I2S writer's sample input.

## Interface
- `SAMPLE_DIV`, 2267: clock cycles per sample tick, ≥2 (100 MHz / 44.1 kHz).
- `clk`  in  1  block clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; rising edge starts playback, low stops it.
- `wave_sel`  in  1  0 = sine, 1 = triangle; sampled only at start and at period wrap.
- `period_count`  in  16  periods to play; 0 = continuous.
- `channel_mask`  in  2  bit1 = left enabled, bit0 = right enabled; a masked channel carries 16'h0000.
- `rom_sel`  out  1  to ROM `sel`.
- `rom_pos`  out  8  to ROM `pos`.
- `rom_wavelength`  in  8  from ROM.
- `rom_value`  in  16  from ROM, same-cycle combinational.
- `sample_data`  out  32  {left[31:16], right[15:0]}.
- `sample_valid`  out  1  sample available.
- `sample_ready`  in  1  sink accepts.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when `period_count` periods complete.
- `underrun`  out  1  sticky; set on dropped tick, cleared on start.

## Operation
- States: IDLE, WAIT_TICK, PRESENT, DONE.
- IDLE: on `enable` high with previous-cycle `enable` low → WAIT_TICK; load divider 0; `rom_pos`←0; `rom_sel`←`wave_sel`; period counter←0; `underrun`←0.
- WAIT_TICK: if `enable` low → IDLE. Else on tick: `sample_data` captures `rom_value` into each unmasked channel; → PRESENT; advance `rom_pos`.
- Position advance: if `rom_pos` ≥ `rom_wavelength`−1 then `rom_pos`←0, period counter +1, `rom_sel`←`wave_sel`; else `rom_pos`+1. `rom_wavelength` of 0 is treated as 1.
- PRESENT: `sample_valid` high, `sample_data` stable until `sample_ready`. On handshake: if `period_count`≠0 and period counter = `period_count` → DONE; else if `enable` low → IDLE; else → WAIT_TICK.
- A tick occurring in PRESENT is dropped: `underrun`←1, sample not replaced, `rom_pos` unchanged.
- `enable` falling in PRESENT does not abort: handshake completes first, then IDLE.
- DONE: `done` high one cycle → IDLE. Restart requires a fresh `enable` rising edge.
- Period counter is 16 bits, saturates at 16'hFFFF in continuous mode (no wrap side effects).

## Timing
- Reset values: state IDLE, `rom_sel` 0, `rom_pos` 0, `sample_data` 0, `sample_valid` 0, `busy` 0, `done` 0, `underrun` 0, divider SAMPLE_DIV−1.
- Divider: free-runs down in all non-IDLE states; tick when 0, reload SAMPLE_DIV−1 next cycle; ticks exactly SAMPLE_DIV cycles apart regardless of stalls.
- Start latency: `enable` rise sampled at cycle N → WAIT_TICK at N+1 with tick → `sample_valid` high at N+2 with `rom_value` for pos 0.
- `sample_valid` deasserts the cycle after handshake; no combinational path ready→valid.
- `done` asserts the cycle after the final handshake.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous), no pending sample survives.

## Structure
- Package `i2s_wave_pkg`: state enum, `SINE_LEN`=44, `TRI_LEN`=16, `SAMPLE_W`=16.
- One sub-module: `sample_rate_divider` (load, run, tick out, parameter SAMPLE_DIV).
- ROM instantiated outside; this block only drives its address.

## Test plan
- SAMPLE_DIV=4, sine, `period_count`=1, ready tied high → 44 samples, first 0x0000/0x0000, 12th 0x7FFF, 34th 0x8001, ticks 4 cycles apart, `done` pulse after 44th handshake, then IDLE.
- Triangle, `period_count`=2 → 32 samples 0x0000..0x000F twice, `rom_pos` wraps 15→0, `done` once.
- `wave_sel` toggled mid-period (`period_count`=0) → table switches only at next pos-0 sample, never mid-period.
- `sample_ready` held low 10 cycles at SAMPLE_DIV=4 → `underrun`=1, held sample unchanged, next sample is next ROM index; `underrun` clears on restart.
- `enable` dropped while PRESENT → valid held until ready, then IDLE, `busy` 0; `channel_mask`=2'b10 → right half 0x0000.
- `rst_n` pulsed low while PRESENT → `sample_valid`, `busy`, `rom_pos` 0 asynchronously; restart yields pos 0 sample at N+2.
